match_controller: RTL

Sequences a full ping-pong match around the ball/LED datapath.
- Decides who serves and issues the serve.
- Paces ball movement with a tick enable that speeds up on every hit.
- Counts points from the datapath's point pulses, detects the winner and holds game-over until a new match is requested.
- Sits between the debounced switch inputs and the ball datapath; drives the score displays.

---
 rtl/match_pkg.sv | 25 ++
 rtl/rally_speed_timer.sv | 62 ++++++
 rtl/match_controller.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared encodings for the ping-pong match controller: FSM states, winner codes,
// serve sides and a saturating score increment.
package match_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_SERVE_WAIT = 2'd0;
  localparam state_t ST_RALLY      = 2'd1;
  localparam state_t ST_PAUSE      = 2'd2;
  localparam state_t ST_GAME_OVER  = 2'd3;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_LEFT  = 2'b01,
    WIN_RIGHT = 2'b10
  } winner_e;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rally_speed_timer.sv
// Ball pacing timer: period register with per-hit decrement clamped at a floor,
// free-running tick counter and registered one-cycle ball_tick.
module rally_speed_timer
  import match_pkg::*;
#(
  parameter int unsigned     CNT_W     = 24,
  parameter logic [CNT_W-1:0] TICK_INIT = 24'd5_000_000,
  parameter logic [CNT_W-1:0] TICK_STEP = 24'd250_000,
  parameter logic [CNT_W-1:0] TICK_MIN  = 24'd1_000_000
) (
  input  logic clk_game,
  input  logic rst,
  input  logic load_init,
  input  logic run,
  input  logic hit,
  output logic ball_tick
);

  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    period_d = period_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (load_init) begin
      period_d = TICK_INIT;
      cnt_d    = '0;
    end else if (run) begin
      // >= rather than == so a hit that shrinks the period below the running
      // count still terminates the current interval instead of wrapping
      if (cnt_q >= period_q - CNT_W'(1)) begin
        tick_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (hit) begin
        if ((period_q > TICK_MIN) && ((period_q - TICK_MIN) >= TICK_STEP))
          period_d = period_q - TICK_STEP;
        else
          period_d = TICK_MIN;
      end
    end
  end

  always_ff @(posedge clk_game) begin
    if (rst) begin
      period_q <= TICK_INIT;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
    end
  end

  assign ball_tick = tick_q;

endmodule

// File: rtl/match_controller.sv
// Ping-pong match sequencer: serve, rally pacing, scoring, win detection.
// Optional deuce rules (win by two, serve swap every point late) with MATCH_DEUCE_EN.
//
// state      | meaning
// SERVE_WAIT | waiting for the serving side's switch edge
// RALLY      | ball in play, ticks running, watching hit/point pulses
// PAUSE      | dead time after a point, then win check
// GAME_OVER  | frozen until both switches are held together
module match_controller
  import match_pkg::*;
#(
  parameter int unsigned      CNT_W     = 24,
  parameter logic [CNT_W-1:0] TICK_INIT = 24'd5_000_000,
  parameter logic [CNT_W-1:0] TICK_STEP = 24'd250_000,
  parameter logic [CNT_W-1:0] TICK_MIN  = 24'd1_000_000,
  parameter int unsigned      PAUSE_CYC = 50_000_000,
  parameter logic [3:0]       WIN_SCORE = 4'd7
) (
  input  logic       clk_game,
  input  logic       rst,
  input  logic       left_sw,
  input  logic       right_sw,
  input  logic       hit,
  input  logic       point_left,
  input  logic       point_right,
  output logic       ball_tick,
  output logic       serve_req,
  output logic       serve_side,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] winner,
  output logic [1:0] state_o
);

  // pause dead time can exceed the tick counter width, so it sizes itself
  localparam int unsigned PAUSE_W = (PAUSE_CYC > 1) ? $clog2(PAUSE_CYC) : 1;

  state_t             state_q, state_d;
  logic               left_q, right_q;
  logic               serve_side_q, serve_side_d;
  logic               serve_req_q, serve_req_d;
  logic [3:0]         score_l_q, score_l_d;
  logic [3:0]         score_r_q, score_r_d;
  winner_e            winner_q, winner_d;
  logic [PAUSE_W-1:0] pause_q, pause_d;

  logic       load_init, run, hit_ok;
  logic       rise_l, rise_r, point_any;
  logic [4:0] score_sum;
  logic       win_l, win_r, toggle;

  assign rise_l    = left_sw & ~left_q;
  assign rise_r    = right_sw & ~right_q;
  assign point_any = point_left | point_right;
  assign score_sum = {1'b0, score_l_q} + {1'b0, score_r_q};

`ifdef MATCH_DEUCE_EN
  assign win_l  = (score_l_q == 4'hF) ||
                  ((score_l_q >= WIN_SCORE) && ({1'b0, score_l_q} >= {1'b0, score_r_q} + 5'd2));
  assign win_r  = (score_r_q == 4'hF) ||
                  ((score_r_q >= WIN_SCORE) && ({1'b0, score_r_q} >= {1'b0, score_l_q} + 5'd2));
  assign toggle = ~score_sum[0] ||
                  ((score_l_q >= WIN_SCORE - 4'd1) && (score_r_q >= WIN_SCORE - 4'd1));
`else
  assign win_l  = (score_l_q == WIN_SCORE);
  assign win_r  = (score_r_q == WIN_SCORE);
  assign toggle = ~score_sum[0];
`endif

  always_comb begin
    state_d      = state_q;
    serve_side_d = serve_side_q;
    serve_req_d  = 1'b0;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    winner_d     = winner_q;
    pause_d      = pause_q;
    load_init    = 1'b0;
    run          = 1'b0;
    hit_ok       = 1'b0;
    case (state_q)
      ST_SERVE_WAIT: begin
        if ((serve_side_q == SIDE_LEFT) ? rise_l : rise_r) begin
          serve_req_d = 1'b1;
          load_init   = 1'b1;
          state_d     = ST_RALLY;
        end
      end
      ST_RALLY: begin
        // a point ends the rally: no tick from this cycle and any hit is dropped
        run    = ~point_any;
        hit_ok = hit & ~point_any;
        if (point_any) begin
          state_d = ST_PAUSE;
          pause_d = PAUSE_W'(PAUSE_CYC - 1);
          if (point_left & ~point_right)  score_l_d = sat_inc4(score_l_q);
          if (point_right & ~point_left)  score_r_d = sat_inc4(score_r_q);
        end
      end
      ST_PAUSE: begin
        if (pause_q == '0) begin
          if (win_l) begin
            winner_d = WIN_LEFT;
            state_d  = ST_GAME_OVER;
          end else if (win_r) begin
            winner_d = WIN_RIGHT;
            state_d  = ST_GAME_OVER;
          end else begin
            if (toggle) serve_side_d = ~serve_side_q;
            state_d = ST_SERVE_WAIT;
          end
        end else begin
          pause_d = pause_q - PAUSE_W'(1);
        end
      end
      default: begin
        if (left_sw & right_sw) begin
          score_l_d    = '0;
          score_r_d    = '0;
          winner_d     = WIN_NONE;
          serve_side_d = SIDE_LEFT;
          load_init    = 1'b1;
          state_d      = ST_SERVE_WAIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_game) begin
    left_q  <= left_sw;
    right_q <= right_sw;
    if (rst) begin
      state_q      <= ST_SERVE_WAIT;
      serve_side_q <= SIDE_LEFT;
      serve_req_q  <= 1'b0;
      score_l_q    <= '0;
      score_r_q    <= '0;
      winner_q     <= WIN_NONE;
      pause_q      <= '0;
    end else begin
      state_q      <= state_d;
      serve_side_q <= serve_side_d;
      serve_req_q  <= serve_req_d;
      score_l_q    <= score_l_d;
      score_r_q    <= score_r_d;
      winner_q     <= winner_d;
      pause_q      <= pause_d;
    end
  end

  rally_speed_timer #(
    .CNT_W    (CNT_W),
    .TICK_INIT(TICK_INIT),
    .TICK_STEP(TICK_STEP),
    .TICK_MIN (TICK_MIN)
  ) u_timer (
    .clk_game (clk_game),
    .rst      (rst),
    .load_init(load_init),
    .run      (run),
    .hit      (hit_ok),
    .ball_tick(ball_tick)
  );

  assign serve_req   = serve_req_q;
  assign serve_side  = serve_side_q;
  assign score_left  = score_l_q;
  assign score_right = score_r_q;
  assign winner      = winner_q;
  assign state_o     = state_q;

endmodule
